// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS31 (x^31 + x^28 + 1) checker.
package prbs_pkg;

    localparam int unsigned PrbsLen = 31;
    localparam int unsigned TapHi   = 30;
    localparam int unsigned TapLo   = 27;

    localparam int unsigned LockCntDefault    = 64;
    localparam int unsigned WinLenDefault     = 256;
    localparam int unsigned UnlockErrsDefault = 8;

    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receive checker: acquires from the line, then flywheels a local
// LFSR and counts mismatches, dropping lock when errors per window become too dense.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = LockCntDefault,
    parameter int unsigned WIN_LEN     = WinLenDefault,
    parameter int unsigned UNLOCK_ERRS = UnlockErrsDefault,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned BIT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count
);

    localparam int unsigned WinW = $clog2(WIN_LEN);
    localparam int unsigned WeW  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [4:0]      FillLast   = 5'(PrbsLen - 1);
    localparam logic [7:0]      LockLast   = 8'(LOCK_CNT - 1);
    localparam logic [WinW-1:0] WinLast    = WinW'(WIN_LEN - 1);
    localparam logic [WeW-1:0]  UnlockLast = WeW'(UNLOCK_ERRS - 1);

    state_e              state_q, state_d;
    logic [PrbsLen-1:0]  r_q, r_d;
    logic [4:0]          fill_q, fill_d;
    logic [7:0]          match_q, match_d;
    logic [WinW-1:0]     win_cnt_q, win_cnt_d;
    logic [WeW-1:0]      win_errs_q, win_errs_d;
    logic                err_pulse_q, err_pulse_d;
    logic                pred, mismatch;
    logic                bit_inc, err_inc;

    assign pred     = r_q[TapHi] ^ r_q[TapLo];
    assign mismatch = din ^ pred;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_errs_d  = win_errs_q;
        err_pulse_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                StSearch: begin
                    r_d = {r_q[PrbsLen-2:0], din};
                    if (fill_q == FillLast) begin
                        state_d = StVerify;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                StVerify: begin
                    // Shifting received data reseeds the register after any mismatch.
                    r_d = {r_q[PrbsLen-2:0], din};
                    if (!mismatch && (r_q != '0)) begin
                        if (match_q == LockLast) begin
                            state_d    = StLocked;
                            match_d    = '0;
                            win_cnt_d  = '0;
                            win_errs_d = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel on the prediction so a line error is not fed back.
                    r_d         = {r_q[PrbsLen-2:0], pred};
                    bit_inc     = 1'b1;
                    win_cnt_d   = win_cnt_q + WinW'(1);
                    err_pulse_d = mismatch;
                    err_inc     = mismatch;
                    if (mismatch && (win_errs_q == UnlockLast)) begin
                        state_d    = StSearch;
                        fill_d     = '0;
                        win_errs_d = '0;
                    end else if (win_cnt_q == WinLast) begin
                        win_errs_d = '0;
                    end else if (mismatch) begin
                        win_errs_d = win_errs_q + WeW'(1);
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSearch;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_cnt),
        .inc  (err_inc),
        .count(err_count)
    );

    sat_counter #(
        .WIDTH(BIT_W)
    ) u_bit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_cnt),
        .inc  (bit_inc),
        .count(bit_count)
    );

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: a recurrence-based PRBS31 source plus a bit-level lock/error model.
module tb_prbs31_checker;

    localparam int AcqBits = 31 + 64;
    localparam int WinLen  = 256;
    localparam int Unlock  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    int errors = 0;
    int checks = 0;

    bit          hist[$];
    bit          m_locked;
    int          m_acq;
    int          m_werr;
    int          m_wpos;
    int unsigned m_err;
    int unsigned m_bits;

    prbs31_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // hist holds the last 31 line bits, oldest first; seed bit 0 is the most recent.
    function automatic void seed_gen(input logic [30:0] s);
        hist.delete();
        for (int i = 30; i >= 0; i--) hist.push_back(s[i]);
    endfunction

    // b[n] = b[n-31] ^ b[n-28]
    function automatic bit next_bit();
        bit b;
        b = hist[0] ^ hist[3];
        hist.push_back(b);
        void'(hist.pop_front());
        return b;
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_acq    = 0;
        m_werr   = 0;
        m_wpos   = 0;
        m_err    = 0;
        m_bits   = 0;
    endfunction

    // One clock: drive a bit (optionally inverted), update the model, check all outputs.
    task automatic step(input bit v, input bit inj, input bit clr);
        bit d;
        bit exp_pulse;
        bit e;
        exp_pulse = 1'b0;
        e = inj && m_locked && v;
        if (v) d = next_bit() ^ e;
        else d = 1'($urandom);
        @(negedge clk);
        din       = d;
        din_valid = v;
        clr_cnt   = clr;
        if (v) begin
            if (!m_locked) begin
                m_acq++;
                if (m_acq == AcqBits) begin
                    m_locked = 1'b1;
                    m_werr   = 0;
                    m_wpos   = 0;
                end
            end else begin
                m_bits++;
                m_wpos++;
                if (e) begin
                    exp_pulse = 1'b1;
                    m_err++;
                    m_werr++;
                end
                if (m_werr == Unlock) begin
                    m_locked = 1'b0;
                    m_acq    = 0;
                    m_werr   = 0;
                end else if (m_wpos == WinLen) begin
                    m_wpos = 0;
                    m_werr = 0;
                end
            end
        end
        if (clr) begin
            m_err  = 0;
            m_bits = 0;
        end
        @(posedge clk);
        #1;
        check("locked", locked, m_locked);
        check("err_pulse", err_pulse, exp_pulse);
        check("err_count", err_count, m_err);
        check("bit_count", bit_count, m_bits);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        model_reset();
        seed_gen(31'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_count", err_count, 16'd0);
        check("rst_bit_count", bit_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean lock from seed 1
        repeat (AcqBits - 1) step(1'b1, 1'b0, 1'b0);
        check("pre_lock", locked, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("lock_at_95", locked, 1'b1);
        repeat (40) step(1'b1, 1'b0, 1'b0);
        check("bits_after_lock", bit_count, 32'd40);

        // Single error, no follow-on errors
        step(1'b1, 1'b1, 1'b0);
        check("single_pulse", err_pulse, 1'b1);
        repeat (50) step(1'b1, 1'b0, 1'b0);
        check("single_count", err_count, 16'd1);
        check("single_locked", locked, 1'b1);

        // Loss of lock: align to a window start, then 8 errors inside it
        for (int i = 0; i < 300 && m_wpos != 0; i++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < Unlock; k++) begin
            repeat ($urandom_range(1, 20)) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
        end
        check("unlock_errs", err_count, 16'd9);
        check("unlocked", locked, 1'b0);
        repeat (AcqBits) step(1'b1, 1'b0, 1'b0);
        check("relock", locked, 1'b1);

        // Asynchronous reset while locked
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_err_count", err_count, 16'd0);
        check("arst_bit_count", bit_count, 32'd0);
        check("arst_err_pulse", err_pulse, 1'b0);
        model_reset();
        seed_gen(31'($urandom) | 31'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Gapped valid with random seed
        for (int i = 0; i < AcqBits + 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("gapped_lock", locked, 1'b1);

        // Clear wins over increment; pulse still issued
        step(1'b1, 1'b1, 1'b1);
        check("clr_err_count", err_count, 16'd0);
        check("clr_err_pulse", err_pulse, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // Random valid gaps and sparse random errors
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
        end

        // All-zero input never locks
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            din       = 1'b0;
            din_valid = 1'b1;
            clr_cnt   = 1'b0;
            @(posedge clk);
            #1;
            check("zero_locked", locked, 1'b0);
            check("zero_err_pulse", err_pulse, 1'b0);
        end
        check("zero_err_count", err_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Serial receive-side checker for the PRBS31 pattern (x^31 + x^28 + 1) emitted by the team's PRBS31 generator; sits directly downstream and consumes its single-bit stream, e.g. looped back through uio/ui pins.
- Self-synchronises to the incoming stream, declares lock, then flywheels a local LFSR.
- Counts bit errors and checked bits, and drops lock when the error density is too high.

Parameters:
- LOCK_CNT, 64: consecutive matching bits required in VERIFY before declaring lock (range 1..255).
- WIN_LEN, 256: length, in valid bits, of the loss-of-lock observation window (power of 2).
- UNLOCK_ERRS, 8: errors within one window that force return to SEARCH (must be <= WIN_LEN).
- ERR_W, 16: width of the error counter.
- BIT_W, 32: width of the checked-bit counter.

Ports:
- clk  in  1  clock, the codebase's single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- din  in  1  received serial PRBS bit.
- din_valid  in  1  qualifies din; nothing advances when low.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  ERR_W  saturating count of errors while LOCKED.
- bit_count  out  BIT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=SEARCH; shift register r=0; fill, match and window counters = 0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0.
- Prediction: pred = r[30] ^ r[27], where r[0] is the most recent bit. This is the same tap pair as the generator. All state and counter updates occur only on cycles with din_valid=1.
- SEARCH:
  - Shift din into r and increment fill.
  - When the 31st valid bit is shifted in, move to VERIFY with match=0.
- VERIFY:
  - Shift din into r.
  - Match (din==pred and r!=0): match+1.
  - Mismatch: match=0, stay in VERIFY; the register self-reseeds from received data.
  - On the valid cycle where match reaches LOCK_CNT, move to LOCKED. locked goes high on the next clk edge, i.e. registered with 1-cycle latency.
- LOCKED:
  - Shift pred (not din) into r, so line errors do not multiply.
  - Each valid bit: bit_count+1, saturating at all-ones; window+1.
  - On mismatch:
    - err_pulse=1 in the following cycle.
    - err_count+1, saturating at all-ones.
    - win_errs+1.
  - If win_errs reaches UNLOCK_ERRS, go to SEARCH: fill=0, locked falls next cycle. The err_pulse for that bit is still issued.
  - When window wraps (WIN_LEN bits), win_errs=0.
- Outside LOCKED, err_pulse=0 and counters hold their values (they are not cleared on lock loss).
- clr_cnt=1 on a cycle also incrementing a counter: clear wins (counter=0); err_pulse is unaffected.
- din_valid=0: all state holds and err_pulse=0.
- Reset mid-operation drops lock immediately (asynchronous); lock reacquires via a full SEARCH.

Decomposition:
- Package prbs_pkg holds:
  - PRBS31 length (31) and tap indices (30, 27);
  - the state enum {SEARCH, VERIFY, LOCKED};
  - default LOCK_CNT, WIN_LEN and UNLOCK_ERRS values.
- One sub-module is natural: sat_counter, a parameterised-width saturating incrementer with synchronous clear. It is instantiated for err_count and bit_count.
- FSM, LFSR and window logic stay in prbs31_checker.

Test Plan:
- Clean lock: generator seeded 31'd1 drives din with din_valid=1 continuously -> locked rises the cycle after the 95th bit (31+64); err_count=0, bit_count=N-95 after N bits.
- Single error: after lock, invert one bit -> exactly one err_pulse the cycle after; err_count=1; locked stays 1; no follow-on errors.
- Loss of lock: after lock, invert 8 bits within 256 -> err_count=8; locked falls the cycle after the 8th error; relock occurs 95 valid bits after clean data resumes.
- Gapped valid: toggle din_valid 1/0 every cycle with clean data -> lock after 95 valid bits (190 cycles); holds during invalid cycles; no err_pulse.
- Clear priority: assert clr_cnt on the same cycle an error bit is checked -> err_count=0 next cycle and err_pulse=1.
- All-zero input: 200 zero bits -> never locked; err_count stays 0. Assert rst_n low while locked -> locked=0 immediately and all counters 0.
